// File: rtl/sid_voice_sched.sv
// sid_voice_sched: time-multiplexes one shared sid_voice datapath across
// all 3*NUM_SIDS voices. On a tick it presents every voice in turn,
// collects the pipelined DCA/OSC results into a shadow bank and publishes
// the complete set at once with a one-cycle valid_o pulse.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   tick            start-of-round strobe
//   model_i         chip model per SID
//   voice_i         per-voice datapath input, index 3*sid + voice
//   dca_model_o     model to the shared sid_voice (registered)
//   dca_voice_o     voice input to the shared sid_voice (registered)
//   dca_voice_i     DCA result from the shared sid_voice
//   dca_osc_i       OSC result from the shared sid_voice
//   voice_o         published DCA results, one per voice
//   osc3_o          published OSC3 (voice 2) per SID
//   valid_o         one-cycle pulse when a new result set appears
//   busy_o          round in progress (issue or drain)
//   overrun_o       one-cycle pulse after a rejected tick

package sid;
    typedef logic [7:0]          reg8_t;
    typedef logic signed [21:0]  s22_t;

    typedef enum logic {
        MOS6581 = 1'b0,
        MOS8580 = 1'b1
    } model_e;

    // Per-voice inputs of the shared waveform selector / DCA
    typedef struct packed {
        logic [3:0]  selector;
        logic [11:0] osc;
        reg8_t       envelope;
    } voice_i_t;
endpackage

module sid_voice_sched #(
    parameter int unsigned NUM_SIDS = 2,
    parameter int unsigned LATENCY  = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            tick,
    input  sid::model_e   [NUM_SIDS-1:0]    model_i,
    input  sid::voice_i_t [3*NUM_SIDS-1:0]  voice_i,
    output sid::model_e                     dca_model_o,
    output sid::voice_i_t                   dca_voice_o,
    input  sid::s22_t                       dca_voice_i,
    input  sid::reg8_t                      dca_osc_i,
    output sid::s22_t     [3*NUM_SIDS-1:0]  voice_o,
    output sid::reg8_t    [NUM_SIDS-1:0]    osc3_o,
    output logic                            valid_o,
    output logic                            busy_o,
    output logic                            overrun_o
);

    localparam int unsigned N  = 3 * NUM_SIDS;
    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_PUBLISH = 2'd3
    } state_e;

    state_e                     r_state;
    logic [SW-1:0]              r_slot;
    logic [DW-1:0]              r_drain;
    logic [LATENCY:0]           r_tag_vld;
    logic [LATENCY:0][SW-1:0]   r_tag_slot;
    sid::s22_t  [N-1:0]         r_shadow_voice;
    sid::reg8_t [NUM_SIDS-1:0]  r_shadow_osc3;

    logic                       w_start;
    logic [SW-1:0]              w_sel_slot;
    sid::voice_i_t              w_sel_voice;
    sid::model_e                w_sel_model;
    logic                       w_cap_vld;
    logic [SW-1:0]              w_cap_slot;
    sid::s22_t  [N-1:0]         w_shadow_voice;
    sid::reg8_t [NUM_SIDS-1:0]  w_shadow_osc3;

    // A tick is only accepted when no round is in flight
    assign w_start    = tick && ((r_state == ST_IDLE) || (r_state == ST_PUBLISH));
    // Slot to present next: 0 on a round start, otherwise the successor
    assign w_sel_slot = (r_state == ST_ISSUE) ? (r_slot + SW'(1)) : SW'(0);
    // Oldest tag in the delay line labels the result now on dca_voice_i
    assign w_cap_vld  = r_tag_vld[LATENCY];
    assign w_cap_slot = r_tag_slot[LATENCY];

    // Live read of the selected voice and its chip model
    always_comb begin
        w_sel_voice = '0;
        w_sel_model = sid::MOS6581;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_sel_slot == SW'(i)) begin
                w_sel_voice = voice_i[i];
                w_sel_model = model_i[i / 3];
            end
        end
    end

    // Shadow bank including this cycle's capture, so the last result of a
    // round can be published on the same edge it is captured
    always_comb begin
        w_shadow_voice = r_shadow_voice;
        w_shadow_osc3  = r_shadow_osc3;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_cap_vld && (w_cap_slot == SW'(i))) begin
                w_shadow_voice[i] = dca_voice_i;
            end
        end
        for (int unsigned j = 0; j < NUM_SIDS; j++) begin
            if (w_cap_vld && (w_cap_slot == SW'(3 * j + 2))) begin
                w_shadow_osc3[j] = dca_osc_i;
            end
        end
    end

    // Round FSM, issue/tag pipeline, shadow bank and published outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_slot         <= '0;
            r_drain        <= '0;
            r_tag_vld      <= '0;
            r_tag_slot     <= '0;
            r_shadow_voice <= '0;
            r_shadow_osc3  <= '0;
            dca_model_o    <= sid::MOS6581;
            dca_voice_o    <= '0;
            voice_o        <= '0;
            osc3_o         <= '0;
            valid_o        <= 1'b0;
            busy_o         <= 1'b0;
            overrun_o      <= 1'b0;
        end else begin
            valid_o        <= 1'b0;
            overrun_o      <= 1'b0;
            dca_voice_o    <= '0;
            r_tag_vld      <= {r_tag_vld[LATENCY-1:0], 1'b0};
            r_tag_slot     <= {r_tag_slot[LATENCY-1:0], SW'(0)};
            r_shadow_voice <= w_shadow_voice;
            r_shadow_osc3  <= w_shadow_osc3;

            case (r_state)
                ST_IDLE, ST_PUBLISH: begin
                    r_state <= ST_IDLE;
                    busy_o  <= 1'b0;
                    if (w_start) begin
                        r_state       <= ST_ISSUE;
                        busy_o        <= 1'b1;
                        r_slot        <= '0;
                        dca_voice_o   <= w_sel_voice;
                        dca_model_o   <= w_sel_model;
                        r_tag_vld[0]  <= 1'b1;
                        r_tag_slot[0] <= '0;
                    end
                end
                ST_ISSUE: begin
                    overrun_o <= tick;
                    if (r_slot == SW'(N - 1)) begin
                        r_state <= ST_DRAIN;
                        r_drain <= '0;
                    end else begin
                        r_slot        <= w_sel_slot;
                        dca_voice_o   <= w_sel_voice;
                        dca_model_o   <= w_sel_model;
                        r_tag_vld[0]  <= 1'b1;
                        r_tag_slot[0] <= w_sel_slot;
                    end
                end
                ST_DRAIN: begin
                    overrun_o <= tick;
                    if (r_drain == DW'(LATENCY - 1)) begin
                        r_state <= ST_PUBLISH;
                        busy_o  <= 1'b0;
                        valid_o <= 1'b1;
                        voice_o <= w_shadow_voice;
                        osc3_o  <= w_shadow_osc3;
                    end else begin
                        r_drain <= r_drain + DW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sid_voice_sched.sv
// Testbench for sid_voice_sched: two instances (2 SIDs / latency 1 and
// 1 SID / latency 2), each driving a stub datapath. Expected timing and
// values come from a round-level model computed from the tick list.
module tb_sid_voice_sched;
    import sid::*;

    localparam int unsigned NS_A = 2;
    localparam int unsigned LAT_A = 1;
    localparam int unsigned N_A = 6;
    localparam int unsigned NS_B = 1;
    localparam int unsigned LAT_B = 2;
    localparam int unsigned N_B = 3;
    localparam int MAXC = 96;
    localparam int MAXR = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                  tick_a, valid_a, busy_a, over_a;
    model_e   [NS_A-1:0]   model_a;
    voice_i_t [N_A-1:0]    voice_a;
    model_e                dca_model_a;
    voice_i_t              dca_voice_a;
    s22_t                  dca_vin_a;
    reg8_t                 dca_osc_a;
    s22_t     [N_A-1:0]    vout_a;
    reg8_t    [NS_A-1:0]   osc3_a;

    logic                  tick_b, valid_b, busy_b, over_b;
    model_e   [NS_B-1:0]   model_b;
    voice_i_t [N_B-1:0]    voice_b;
    model_e                dca_model_b;
    voice_i_t              dca_voice_b;
    s22_t                  dca_vin_b;
    reg8_t                 dca_osc_b;
    s22_t     [N_B-1:0]    vout_b;
    reg8_t    [NS_B-1:0]   osc3_b;

    sid_voice_sched #(.NUM_SIDS(NS_A), .LATENCY(LAT_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .tick(tick_a), .model_i(model_a), .voice_i(voice_a),
        .dca_model_o(dca_model_a), .dca_voice_o(dca_voice_a), .dca_voice_i(dca_vin_a),
        .dca_osc_i(dca_osc_a), .voice_o(vout_a), .osc3_o(osc3_a), .valid_o(valid_a),
        .busy_o(busy_a), .overrun_o(over_a)
    );

    sid_voice_sched #(.NUM_SIDS(NS_B), .LATENCY(LAT_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .tick(tick_b), .model_i(model_b), .voice_i(voice_b),
        .dca_model_o(dca_model_b), .dca_voice_o(dca_voice_b), .dca_voice_i(dca_vin_b),
        .dca_osc_i(dca_osc_b), .voice_o(vout_b), .osc3_o(osc3_b), .valid_o(valid_b),
        .busy_o(busy_b), .overrun_o(over_b)
    );

    // Stub datapath transfer functions
    function automatic s22_t stub_voice(input voice_i_t v, input model_e m);
        return 22'({m, v.selector, v.envelope});
    endfunction

    function automatic reg8_t stub_osc(input voice_i_t v);
        return v.osc[7:0] + 8'hA0;
    endfunction

    voice_i_t pipe_va [LAT_A];
    model_e   pipe_ma [LAT_A];
    voice_i_t pipe_vb [LAT_B];
    model_e   pipe_mb [LAT_B];

    always @(posedge clk) begin
        pipe_va[0] <= dca_voice_a;
        pipe_ma[0] <= dca_model_a;
        for (int i = 1; i < int'(LAT_A); i++) begin
            pipe_va[i] <= pipe_va[i-1];
            pipe_ma[i] <= pipe_ma[i-1];
        end
        pipe_vb[0] <= dca_voice_b;
        pipe_mb[0] <= dca_model_b;
        for (int i = 1; i < int'(LAT_B); i++) begin
            pipe_vb[i] <= pipe_vb[i-1];
            pipe_mb[i] <= pipe_mb[i-1];
        end
    end

    assign dca_vin_a = stub_voice(pipe_va[LAT_A-1], pipe_ma[LAT_A-1]);
    assign dca_osc_a = stub_osc(pipe_va[LAT_A-1]);
    assign dca_vin_b = stub_voice(pipe_vb[LAT_B-1], pipe_mb[LAT_B-1]);
    assign dca_osc_b = stub_osc(pipe_vb[LAT_B-1]);

    int n_assert = 0;
    int n_fail = 0;
    int ticks[$];
    voice_i_t rnd_voice [MAXR][6];
    model_e   rnd_model [MAXR][2];
    s22_t     cur_pub   [2][6];
    reg8_t    cur_osc   [2][2];
    model_e   cur_model [2];

    task automatic check(input string tag, input int c, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, c, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < 6; s++) cur_pub[d][s] = '0;
            for (int j = 0; j < 2; j++) cur_osc[d][j] = '0;
            cur_model[d] = MOS6581;
        end
    endtask

    task automatic check_zero(input string name, input int c);
        check({name, ".valid_a"}, c, 32'(valid_a), 32'd0);
        check({name, ".busy_a"},  c, 32'(busy_a),  32'd0);
        check({name, ".over_a"},  c, 32'(over_a),  32'd0);
        check({name, ".dv_a"},    c, 32'(dca_voice_a), 32'd0);
        check({name, ".dm_a"},    c, 32'(dca_model_a), 32'(MOS6581));
        for (int s = 0; s < int'(N_A); s++)
            check($sformatf("%s.voice_a%0d", name, s), c, 32'(vout_a[s]), 32'd0);
        for (int j = 0; j < int'(NS_A); j++)
            check($sformatf("%s.osc3_a%0d", name, j), c, 32'(osc3_a[j]), 32'd0);
        check({name, ".valid_b"}, c, 32'(valid_b), 32'd0);
        check({name, ".busy_b"},  c, 32'(busy_b),  32'd0);
        check({name, ".dv_b"},    c, 32'(dca_voice_b), 32'd0);
        for (int s = 0; s < int'(N_B); s++)
            check($sformatf("%s.voice_b%0d", name, s), c, 32'(vout_b[s]), 32'd0);
        check({name, ".osc3_b0"}, c, 32'(osc3_b[0]), 32'd0);
    endtask

    // Runs ncyc cycles on one instance; ticks[] are cycle numbers, and
    // round r's inputs (rnd_*[r]) are applied at the r-th accepted tick.
    task automatic run(input bit sel, input int ncyc, input string name);
        int n, lat, ns, last, r_app;
        int acc_t[$];
        logic exp_valid [MAXC];
        logic exp_over  [MAXC];
        logic exp_busy  [MAXC];
        int pub_r [MAXC];
        int iss_r [MAXC];
        int iss_k [MAXC];
        n   = sel ? int'(N_B) : int'(N_A);
        lat = sel ? int'(LAT_B) : int'(LAT_A);
        ns  = sel ? int'(NS_B) : int'(NS_A);
        for (int c = 0; c < MAXC; c++) begin
            exp_valid[c] = 1'b0; exp_over[c] = 1'b0; exp_busy[c] = 1'b0;
            pub_r[c] = -1; iss_r[c] = -1; iss_k[c] = 0;
        end
        last = -1000;
        foreach (ticks[i]) begin
            int t = ticks[i];
            if (t >= last + n + lat + 1) begin
                acc_t.push_back(t);
                last = t;
                for (int k = 0; k < n; k++) begin
                    if (t + 1 + k < ncyc) begin
                        iss_r[t+1+k] = acc_t.size() - 1;
                        iss_k[t+1+k] = k;
                    end
                end
                for (int c = t + 1; c <= t + n + lat && c < ncyc; c++) exp_busy[c] = 1'b1;
                if (t + n + lat + 1 < ncyc) begin
                    exp_valid[t+n+lat+1] = 1'b1;
                    pub_r[t+n+lat+1] = acc_t.size() - 1;
                end
            end else if (t + 1 < ncyc) begin
                exp_over[t+1] = 1'b1;
            end
        end

        r_app = 0;
        for (int c = 0; c < ncyc; c++) begin
            logic ob_valid, ob_busy, ob_over, tk;
            voice_i_t ob_dv;
            model_e ob_dm;
            s22_t ob_v;
            reg8_t ob_o;
            logic [31:0] exp_dv;
            @(negedge clk);
            if (pub_r[c] >= 0) begin
                for (int s = 0; s < n; s++)
                    cur_pub[sel][s] = stub_voice(rnd_voice[pub_r[c]][s], rnd_model[pub_r[c]][s/3]);
                for (int j = 0; j < ns; j++)
                    cur_osc[sel][j] = stub_osc(rnd_voice[pub_r[c]][3*j+2]);
            end
            if (iss_r[c] >= 0) cur_model[sel] = rnd_model[iss_r[c]][iss_k[c]/3];
            exp_dv = (iss_r[c] >= 0) ? 32'(rnd_voice[iss_r[c]][iss_k[c]]) : 32'd0;
            if (sel) begin
                ob_valid = valid_b; ob_busy = busy_b; ob_over = over_b;
                ob_dv = dca_voice_b; ob_dm = dca_model_b;
            end else begin
                ob_valid = valid_a; ob_busy = busy_a; ob_over = over_a;
                ob_dv = dca_voice_a; ob_dm = dca_model_a;
            end
            check({name, ".valid"},   c, 32'(ob_valid), 32'(exp_valid[c]));
            check({name, ".busy"},    c, 32'(ob_busy),  32'(exp_busy[c]));
            check({name, ".overrun"}, c, 32'(ob_over),  32'(exp_over[c]));
            check({name, ".dca_voice"}, c, 32'(ob_dv), exp_dv);
            check({name, ".dca_model"}, c, 32'(ob_dm), 32'(cur_model[sel]));
            for (int s = 0; s < n; s++) begin
                ob_v = sel ? vout_b[s] : vout_a[s];
                check($sformatf("%s.voice_o%0d", name, s), c, 32'(ob_v), 32'(cur_pub[sel][s]));
            end
            for (int j = 0; j < ns; j++) begin
                ob_o = sel ? osc3_b[j] : osc3_a[j];
                check($sformatf("%s.osc3_o%0d", name, j), c, 32'(ob_o), 32'(cur_osc[sel][j]));
            end

            tk = 1'b0;
            foreach (ticks[i]) if (ticks[i] == c) tk = 1'b1;
            if (r_app < acc_t.size() && acc_t[r_app] == c) begin
                for (int s = 0; s < n; s++) begin
                    if (sel) voice_b[s] = rnd_voice[r_app][s];
                    else     voice_a[s] = rnd_voice[r_app][s];
                end
                for (int j = 0; j < ns; j++) begin
                    if (sel) model_b[j] = rnd_model[r_app][j];
                    else     model_a[j] = rnd_model[r_app][j];
                end
                r_app++;
            end
            if (sel) tick_b = tk;
            else     tick_a = tk;
        end
    endtask

    task automatic set_round(input int r, input int env_base, input int sel_mul,
                             input model_e m0, input model_e m1);
        for (int s = 0; s < 6; s++) begin
            rnd_voice[r][s].selector = 4'((s * sel_mul) & 15);
            rnd_voice[r][s].osc      = 12'(s);
            rnd_voice[r][s].envelope = 8'(env_base + s);
        end
        rnd_model[r][0] = m0;
        rnd_model[r][1] = m1;
    endtask

    task automatic rand_rounds();
        for (int r = 0; r < MAXR; r++) begin
            for (int s = 0; s < 6; s++) begin
                rnd_voice[r][s].selector = 4'($urandom);
                rnd_voice[r][s].osc      = 12'($urandom);
                rnd_voice[r][s].envelope = 8'($urandom);
            end
            rnd_model[r][0] = model_e'(1'($urandom));
            rnd_model[r][1] = model_e'(1'($urandom));
        end
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        tick_a = 1'b0;
        tick_b = 1'b0;
        voice_a = '0;
        voice_b = '0;
        for (int j = 0; j < int'(NS_A); j++) model_a[j] = MOS6581;
        model_b[0] = MOS6581;
        clear_model();

        repeat (3) @(negedge clk);
        check_zero("reset", 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("post_reset", 0);

        // Single round with OSC3 routing
        set_round(0, 8'h10, 0, MOS6581, MOS6581);
        ticks = {};
        ticks.push_back(0);
        run(1'b0, 12, "single");

        // Rejected tick mid-round
        set_round(0, 8'h30, 3, MOS8580, MOS6581);
        ticks = {};
        ticks.push_back(0);
        ticks.push_back(4);
        run(1'b0, 12, "overrun");

        // Back-to-back rounds
        set_round(0, 8'h10, 0, MOS6581, MOS6581);
        set_round(1, 8'h20, 0, MOS6581, MOS6581);
        ticks = {};
        ticks.push_back(0);
        ticks.push_back(8);
        run(1'b0, 20, "b2b");

        // Reset in the middle of a round
        set_round(0, 8'h50, 1, MOS8580, MOS8580);
        ticks = {};
        ticks.push_back(0);
        run(1'b0, 4, "pre_rst");
        @(negedge clk);
        tick_a = 1'b0;
        rst_n = 1'b0;
        #1;
        clear_model();
        check_zero("rst_mid", 4);
        @(negedge clk);
        check_zero("rst_hold", 5);
        @(negedge clk);
        check_zero("rst_hold", 6);
        rst_n = 1'b1;
        set_round(0, 8'h40, 0, MOS6581, MOS8580);
        ticks = {};
        ticks.push_back(3);
        run(1'b0, 14, "post_rst");

        // One SID, latency 2
        set_round(0, 8'h10, 0, MOS6581, MOS6581);
        ticks = {};
        ticks.push_back(0);
        run(1'b1, 10, "lat2");

        // Random tick spacing and random voice data on both instances
        for (int d = 0; d < 2; d++) begin
            int span;
            span = (d == 0) ? int'(N_A + LAT_A) : int'(N_B + LAT_B);
            rand_rounds();
            ticks = {};
            t = int'($urandom_range(0, 3));
            while (t < 56) begin
                ticks.push_back(t);
                t += int'($urandom_range(1, span + 3));
            end
            run(d[0], 70, (d == 0) ? "rand_a" : "rand_b");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sid_voice_sched.md
# sid_voice_sched

Time-multiplexing scheduler that shares one `sid_voice` instance (waveform selector plus voice DCA) across all voices of `NUM_SIDS` emulated SID chips. On each sample tick it issues every voice's `voice_i` and `model` to the shared datapath, one voice per cycle. It captures the delayed DCA and OSC results into a shadow bank, then publishes all results atomically with a one-cycle `valid_o` pulse. It sits between the per-voice oscillator/envelope generators and the filter/mixer stage.

## Interface
- `NUM_SIDS`, default 2: number of SID chips; slot count `N = 3*NUM_SIDS`.
- `LATENCY`, default 1: cycles from `dca_voice_o` presentation to valid `dca_voice_i`/`dca_osc_i`. This matches the shared `sid_voice`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  start-of-round strobe, one cycle.
- `model_i`  in  `NUM_SIDS` x `sid::model_e`  chip model per SID.
- `voice_i`  in  `N` x `sid::voice_i_t`  per-voice waveform and envelope. Index `s = 3*sid + voice`.
- `dca_model_o`  out  `sid::model_e`  model to the shared `sid_voice`. Registered.
- `dca_voice_o`  out  `sid::voice_i_t`  voice input to the shared `sid_voice`. Registered.
- `dca_voice_i`  in  `sid::s22_t`  `voice_o` from the shared `sid_voice`.
- `dca_osc_i`  in  `sid::reg8_t`  `osc_o` from the shared `sid_voice`.
- `voice_o`  out  `N` x `sid::s22_t`  published DCA results, one per voice.
- `osc3_o`  out  `NUM_SIDS` x `sid::reg8_t`  published OSC3 (voice index 2) per SID.
- `valid_o`  out  1  one-cycle pulse: a new result set is visible this cycle.
- `busy_o`  out  1  a round is in progress.
- `overrun_o`  out  1  one-cycle pulse: `tick` was rejected.

## Operation
- **FSM states:**
  - IDLE: waiting for `tick`.
  - ISSUE: presenting slots 0..N-1.
  - DRAIN: LATENCY cycles collecting the remaining results.
  - PUBLISH: one cycle.
- **Transitions:**
  - IDLE→ISSUE on `tick`.
  - ISSUE→DRAIN after slot N-1 is presented.
  - DRAIN→PUBLISH after LATENCY cycles.
  - PUBLISH→IDLE unconditionally.
  - PUBLISH also accepts a `tick`, going straight to ISSUE, so back-to-back rounds have a period of N+LATENCY+1 cycles.
- **Issue:**
  - Slot counter `s`, `$clog2(N)` bits, counts 0..N-1 with no wrap inside a round.
  - `dca_voice_o <= voice_i[s]` and `dca_model_o <= model_i[s/3]`, registered.
  - `voice_i`/`model_i` are read live. Upstream holds them stable from `tick` until `valid_o`.
- **Capture:**
  - A delay line of slot indices, LATENCY+1 deep, tags each result.
  - When the tagged slot `t` is valid: `shadow_voice[t] <= dca_voice_i`.
  - If `t%3 == 2`: `shadow_osc3[t/3] <= dca_osc_i`.
- **Publish:** `voice_o <= shadow_voice`, `osc3_o <= shadow_osc3`, and `valid_o` pulses in the same cycle the new values appear. Outputs are unchanged between publishes.
- **Idle drive:** outside ISSUE, `dca_voice_o` is all zeros (selector 0, envelope 0) and `dca_model_o` holds its last value.
- **Rejected tick:** a `tick` in ISSUE or DRAIN is ignored, pulses `overrun_o` the next cycle, and does not disturb the current round.
- **Reset (async, mid-round included):**
  - State returns to IDLE; `s`, the delay line and the shadow bank are cleared.
  - All outputs go to 0; `dca_model_o` = `MOS6581`.
  - No `valid_o` is emitted for the aborted round.

## Timing
- `tick` high in cycle 0 (IDLE).
- Slot `k` is on `dca_voice_o` in cycle 1+k, k = 0..N-1.
- The result for slot `k` is on `dca_voice_i` in cycle 1+k+LATENCY and is captured at the end of that cycle.
- `valid_o` and the new `voice_o`/`osc3_o` are visible in cycle N+LATENCY+1. With defaults (N=6): cycle 8.
- `busy_o` is high in cycles 1..N+LATENCY, i.e. ISSUE and DRAIN, and low in IDLE and PUBLISH.
- `overrun_o` is high the cycle after a rejected `tick`.

## Test plan
- **Single round:** use defaults and a stub datapath with `dca_voice_i = envelope` delayed 1 cycle. Set `voice_i[s].envelope = 0x10+s`. Pulse `tick` at cycle 0.
  - Required: `valid_o` only at cycle 8.
  - Required: `voice_o = {0x10..0x15}`.
  - Required: `busy_o` high in cycles 1..7.
- **OSC3 routing:** stub `dca_osc_i` = slot index+0xA0. After one round, required: `osc3_o[0]=0xA2` and `osc3_o[1]=0xA5`; the other slots' `osc_i` are ignored.
- **Overrun:** pulse `tick` at cycles 0 and 4.
  - Required: `overrun_o` at cycle 5.
  - Required: exactly one `valid_o`, at cycle 8, with values unaffected.
- **Back-to-back:** pulse `tick` at cycles 0 and 8, changing the envelopes to `0x20+s` after cycle 8.
  - Required: `valid_o` at 8 (values `0x10+s`) and at 16 (values `0x20+s`).
  - Required: no overrun.
- **Reset mid-round:** assert `rst_n=0` at cycle 4, release at cycle 6, then pulse `tick` at cycle 10.
  - Required: all outputs 0 immediately, and no `valid_o` at cycle 8.
  - Required: a clean round with `valid_o` at cycle 18.
- **LATENCY=2, NUM_SIDS=1:** `tick` at cycle 0. Required: `valid_o` at cycle 6, and slot tags align so `voice_o[k] = 0x10+k`.
